// File: rtl/svn_pkg.sv
// Shared constants and types for the seven-segment capture block.
package svn_pkg;

  // Width of the segment vector {CA,CB,CC,CD,CE,CF,CG}.
  localparam int SEG_W = 7;

  // Nibble used for blank and for unrecognised patterns.
  localparam logic [3:0] NIBBLE_BLANK = 4'hF;

  // Active-low segment patterns, bit 6 = CA ... bit 0 = CG.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // How many anodes are selected in the current cycle.
  typedef enum logic [1:0] {
    AN_IDLE  = 2'd0,
    AN_ONE   = 2'd1,
    AN_MULTI = 2'd2
  } an_kind_e;

  // One captured digit as held in the shadow frame.
  typedef struct packed {
    logic [3:0] nibble;
    logic       dp;
    logic       blank;
  } slot_t;

endpackage

// File: rtl/svn_encdr.sv
// Combinational decoder from an active-low segment vector to a digit nibble.
module svn_encdr
  import svn_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       nibble,
  output logic             blank,
  output logic             illegal
);

  // Pattern lookup; anything not in the table is flagged illegal.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    nibble  = NIBBLE_BLANK;
    blank   = 1'b0;
    illegal = 1'b0;
    case (seg)
      SEG_0:     nibble = 4'd0;
      SEG_1:     nibble = 4'd1;
      SEG_2:     nibble = 4'd2;
      SEG_3:     nibble = 4'd3;
      SEG_4:     nibble = 4'd4;
      SEG_5:     nibble = 4'd5;
      SEG_6:     nibble = 4'd6;
      SEG_7:     nibble = 4'd7;
      SEG_8:     nibble = 4'd8;
      SEG_9:     nibble = 4'd9;
      SEG_BLANK: blank  = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/svn_capture.sv
// Samples a multiplexed seven-segment display bus and assembles complete
// frames of NUM_DIG digits, presented through a valid/ready handshake.
module svn_capture
  import svn_pkg::*;
#(
  parameter int STABLE  = 2,  // identical cycles required before sampling, 1..15
  parameter int NUM_DIG = 8
) (
  input  logic                 clk,
  input  logic                 sys_rst_n,
  input  logic                 CA,
  input  logic                 CB,
  input  logic                 CC,
  input  logic                 CD,
  input  logic                 CE,
  input  logic                 CF,
  input  logic                 CG,
  input  logic                 DP,
  input  logic [NUM_DIG-1:0]   AN,
  output logic [4*NUM_DIG-1:0] frame_data,
  output logic [NUM_DIG-1:0]   frame_dp,
  output logic [NUM_DIG-1:0]   frame_blank,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 err,
  output logic                 overrun
);

  localparam int         IN_W      = NUM_DIG + SEG_W + 1;
  localparam int         IDX_W     = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [3:0] STABLE_C  = 4'(STABLE);
  localparam logic [3:0] STABLE_M1 = 4'(STABLE - 1);

  logic [SEG_W-1:0]   seg;
  logic [IN_W-1:0]    cur;
  logic [IN_W-1:0]    prev;
  logic [3:0]         cnt;
  logic               same;
  logic               sample;

  logic [3:0]         dec_nibble;
  logic               dec_blank;
  logic               dec_illegal;

  an_kind_e           an_kind;
  logic [IDX_W-1:0]   an_idx;

  logic               write_en;
  logic [NUM_DIG-1:0] seen;
  logic [NUM_DIG-1:0] seen_next;
  logic               seen_full;
  logic               copy;
  logic               drop;

  slot_t              shadow [NUM_DIG];
  logic [4*NUM_DIG-1:0] shadow_data;
  logic [NUM_DIG-1:0]   shadow_dp;
  logic [NUM_DIG-1:0]   shadow_blank;

  assign seg  = {CA, CB, CC, CD, CE, CF, CG};
  assign cur  = {AN, seg, DP};
  assign same = (cur == prev);

  // A sample fires on the cycle the counter steps up to STABLE; once it
  // saturates no further sample occurs until the inputs change.
  assign sample = same && (cnt == STABLE_M1);

  svn_encdr u_encdr (
    .seg     (seg),
    .nibble  (dec_nibble),
    .blank   (dec_blank),
    .illegal (dec_illegal)
  );

  // Input history and stability counter.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    if (!sys_rst_n) begin
      prev <= '1;
      cnt  <= '0;
    end else begin
      prev <= cur;
      if (!same)
        cnt <= '0;
      else if (cnt != STABLE_C)
        cnt <= cnt + 4'd1;
    end
  end

  // Classify the anode selects: none, exactly one (with its index), or several.
  always_comb begin
    an_kind = AN_IDLE;
    an_idx  = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (!AN[i]) begin
        if (an_kind == AN_IDLE) begin
          an_kind = AN_ONE;
          an_idx  = IDX_W'(i);
        end else begin
          an_kind = AN_MULTI;
        end
      end
    end
  end

  assign write_en  = sample && (an_kind == AN_ONE);
  assign seen_full = &seen;
  assign copy      = seen_full && (!frame_valid || frame_ready);
  assign drop      = seen_full && frame_valid && !frame_ready;

  // Completing a frame clears the seen mask; a write in the same cycle still lands.
  always_comb begin
    seen_next = seen_full ? '0 : seen;
    if (write_en)
      seen_next[an_idx] = 1'b1;
  end

  // Shadow slots are gated by the seen mask, so they carry no reset.
  always_ff @(posedge clk) begin
    // NOTE: data storage is left unreset; validity is tracked by the reset seen mask instead.
    if (write_en)
      shadow[an_idx] <= '{nibble: dec_nibble, dp: ~DP, blank: dec_blank};
  end

  // Flatten the shadow slots into the frame output layout.
  always_comb begin
    shadow_data  = '0;
    shadow_dp    = '0;
    shadow_blank = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      shadow_data[4*i +: 4] = shadow[i].nibble;
      shadow_dp[i]          = shadow[i].dp;
      shadow_blank[i]       = shadow[i].blank;
    end
  end

  // Capture bookkeeping, status pulses and the presented frame.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seen        <= '0;
      err         <= 1'b0;
      overrun     <= 1'b0;
      frame_data  <= '0;
      frame_dp    <= '0;
      frame_blank <= '0;
      frame_valid <= 1'b0;
    end else begin
      seen    <= seen_next;
      err     <= sample && ((an_kind == AN_MULTI) ||
                            ((an_kind == AN_ONE) && dec_illegal));
      overrun <= drop;
      if (copy) begin
        frame_data  <= shadow_data;
        frame_dp    <= shadow_dp;
        frame_blank <= shadow_blank;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_svn_capture.sv
// Directed self-checking bench for svn_capture (STABLE=2, NUM_DIG=8).
module tb_svn_capture;

  logic        clk;
  logic        sys_rst_n;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;
  logic [7:0]  AN;
  logic [31:0] frame_data;
  logic [7:0]  frame_dp;
  logic [7:0]  frame_blank;
  logic        frame_valid;
  logic        frame_ready;
  logic        err;
  logic        overrun;

  int tests  = 0;
  int failed = 0;

  svn_capture #(.STABLE(2), .NUM_DIG(8)) dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .CA          (CA),
    .CB          (CB),
    .CC          (CC),
    .CD          (CD),
    .CE          (CE),
    .CF          (CF),
    .CG          (CG),
    .DP          (DP),
    .AN          (AN),
    .frame_data  (frame_data),
    .frame_dp    (frame_dp),
    .frame_blank (frame_blank),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .err         (err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written segment patterns, {CA..CG}, active-low.
  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] an, input logic [6:0] seg, input logic dp);
    AN = an;
    {CA, CB, CC, CD, CE, CF, CG} = seg;
    DP = dp;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold inputs for 3 edges; returns #1 after the edge on which the sample lands.
  task automatic put(input logic [7:0] an, input logic [6:0] seg, input logic dp);
    set_in(an, seg, dp);
    step(3);
  endtask

  task automatic digit(input int idx, input int val, input logic dp_lit);
    put(~(8'b1 << idx), seg_of(val), ~dp_lit);
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n   = 1'b0;
    frame_ready = 1'b0;
    set_in(8'hFF, 7'b1111111, 1'b1);
    #3;
    check("rst_valid", 32'(frame_valid), 32'd0);
    check("rst_data",  frame_data,       32'd0);
    check("rst_err",   32'(err),         32'd0);
    check("rst_ovr",   32'(overrun),     32'd0);
    #9 sys_rst_n = 1'b1;
    step(1);

    // Basic frame: digit i shows i.
    for (int i = 0; i < 8; i++) digit(i, i, 1'b0);
    check("basic_no_valid_yet", 32'(frame_valid), 32'd0);
    step(1);
    check("basic_valid", 32'(frame_valid), 32'd1);
    check("basic_data",  frame_data,       32'h76543210);
    check("basic_blank", 32'(frame_blank), 32'h00);
    check("basic_dp",    32'(frame_dp),    32'h00);
    check("basic_err",   32'(err),         32'd0);
    accept();
    check("accept_clears", 32'(frame_valid), 32'd0);

    // One-cycle transient on digit 0 must not count as a sample.
    set_in(8'b11111110, seg_of(5), 1'b1);
    step(1);
    for (int i = 1; i < 8; i++) digit(i, i, 1'b0);
    step(2);
    check("transient_no_frame", 32'(frame_valid), 32'd0);
    digit(0, 9, 1'b0);
    step(1);
    check("transient_valid", 32'(frame_valid), 32'd1);
    check("transient_data",  frame_data,       32'h76543219);
    accept();

    // Two anodes low: one-cycle err, no write; blank and illegal digits; DP on digit 5.
    digit(0, 0, 1'b0);
    digit(1, 1, 1'b0);
    set_in(8'b11111100, seg_of(8), 1'b1);
    step(2);
    check("multi_an_err_before", 32'(err), 32'd0);
    step(1);
    check("multi_an_err_pulse", 32'(err), 32'd1);
    step(1);
    check("multi_an_err_end", 32'(err), 32'd0);
    put(8'b11111011, 7'b1111111, 1'b1);
    check("blank_no_err", 32'(err), 32'd0);
    put(8'b11110111, 7'b1010101, 1'b1);
    check("illegal_err", 32'(err), 32'd1);
    digit(4, 4, 1'b0);
    digit(5, 5, 1'b1);
    digit(6, 6, 1'b0);
    digit(7, 7, 1'b0);
    step(1);
    check("mix_valid", 32'(frame_valid), 32'd1);
    check("mix_data",  frame_data,       32'h7654FF10);
    check("mix_dp",    32'(frame_dp),    32'h20);
    check("mix_blank", 32'(frame_blank), 32'h04);
    accept();

    // Backpressure: frame A held, frame B dropped, frame C replaces A on accept.
    for (int i = 0; i < 8; i++) digit(i, 7 - i, 1'b0);
    step(1);
    check("bp_a_valid", 32'(frame_valid), 32'd1);
    check("bp_a_data",  frame_data,       32'h01234567);
    for (int i = 0; i < 8; i++) digit(i, 8, 1'b0);
    check("bp_no_ovr_early", 32'(overrun), 32'd0);
    step(1);
    check("bp_overrun",  32'(overrun),     32'd1);
    check("bp_a_kept",   frame_data,       32'h01234567);
    check("bp_a_valid2", 32'(frame_valid), 32'd1);
    step(1);
    check("bp_overrun_end", 32'(overrun), 32'd0);
    for (int i = 0; i < 8; i++) digit(i, 9, 1'b0);
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
    check("bp_c_valid", 32'(frame_valid), 32'd1);
    check("bp_c_data",  frame_data,       32'h99999999);
    check("bp_c_noovr", 32'(overrun),     32'd0);
    step(1);
    check("bp_c_hold", 32'(frame_valid), 32'd1);
    accept();
    check("bp_c_accept", 32'(frame_valid), 32'd0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 4; i++) digit(i, 5, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    set_in(8'hFF, 7'b1111111, 1'b1);
    #1;
    check("mid_rst_data",  frame_data,       32'd0);
    check("mid_rst_valid", 32'(frame_valid), 32'd0);
    #3 sys_rst_n = 1'b1;
    step(1);
    for (int i = 4; i < 8; i++) digit(i, 2, 1'b0);
    step(2);
    check("post_rst_partial", 32'(frame_valid), 32'd0);
    for (int i = 0; i < 4; i++) digit(i, 6, 1'b0);
    step(1);
    check("post_rst_valid", 32'(frame_valid), 32'd1);
    check("post_rst_data",  frame_data,       32'h22226666);
    check("post_rst_blank", 32'(frame_blank), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
